// File: rtl/ex_div_pkg.sv
// Shared EX-stage defines: ALU op codes for division and the divider's
// state encodings, handshake levels and operand-magnitude helper.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic       DIV_RESULT_READY     = 1'b1;
  localparam logic       DIV_RESULT_NOT_READY = 1'b0;
  localparam logic       DIV_START            = 1'b1;
  localparam logic       DIV_STOP             = 1'b0;
  localparam logic [7:0] EXE_DIV_OP           = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP          = 8'b0001_1011;
  localparam logic [5:0] DIV_STEPS            = 6'd32;

  // Two's-complement magnitude of a negative signed operand; pass-through otherwise.
  function automatic logic [31:0] div_mag(input logic [31:0] val, input logic is_signed);
    logic [31:0] mag;
    if (is_signed && val[31]) begin
      mag = ~val + 32'd1;
    end else begin
      mag = val;
    end
    return mag;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] val, input logic neg);
    logic [31:0] res;
    if (neg) begin
      res = ~val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/ex_div.sv
// 32-bit restoring divider for the EX stage (DIV/DIVU): one quotient bit per
// clock, annulable while iterating, result held until start_i drops.
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic [64:0] r_dividend;
  logic [64:0] w_dividend_nxt;
  logic [31:0] r_divisor;
  logic [31:0] w_divisor_nxt;
  logic        r_neg_q;
  logic        w_neg_q_nxt;
  logic        r_neg_r;
  logic        w_neg_r_nxt;
  logic [63:0] r_result;
  logic [63:0] w_result_nxt;
  logic        r_ready;
  logic        w_ready_nxt;

  // Partial remainder sits in [64:32], quotient bits shift in at [0].
  logic [64:0] w_shift;
  logic [33:0] w_diff;
  assign w_shift = r_dividend << 1;
  assign w_diff  = {1'b0, w_shift[64:32]} - {2'b00, r_divisor};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= DIV_FREE;
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= 64'd0;
      r_ready    <= DIV_RESULT_NOT_READY;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  // Next-state, iteration step and output update.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;
    case (r_state)
      DIV_FREE: begin
        if ((start_i == DIV_START) && !annul_i) begin
          w_dividend_nxt = {33'd0, div_mag(opdata1_i, signed_div_i)};
          w_divisor_nxt  = div_mag(opdata2_i, signed_div_i);
          w_neg_q_nxt    = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          w_neg_r_nxt    = signed_div_i & opdata1_i[31];
          w_cnt_nxt      = 6'd0;
          if (opdata2_i == 32'd0) begin
            w_state_nxt = DIV_BY_ZERO;
          end else begin
            w_state_nxt = DIV_ON;
          end
        end else begin
          w_state_nxt = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        w_state_nxt  = DIV_END;
        w_result_nxt = 64'd0;
        w_ready_nxt  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_cnt_nxt    = 6'd0;
          w_result_nxt = 64'd0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else if (r_cnt != DIV_STEPS) begin
          // Borrow clear means the trial subtraction fits: keep it and shift in a 1.
          if (!w_diff[33]) begin
            w_dividend_nxt = {w_diff[32:0], w_shift[31:1], 1'b1};
          end else begin
            w_dividend_nxt = w_shift;
          end
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_result_nxt = {neg_if(r_dividend[63:32], r_neg_r), neg_if(r_dividend[31:0], r_neg_q)};
          w_ready_nxt  = DIV_RESULT_READY;
          w_state_nxt  = DIV_END;
          w_cnt_nxt    = 6'd0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = 64'd0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          w_state_nxt = DIV_END;
        end
      end
      default: begin
        w_state_nxt  = DIV_FREE;
        w_cnt_nxt    = 6'd0;
        w_result_nxt = 64'd0;
        w_ready_nxt  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table plus directed annul/reset sequences,
// with expected results queued at issue and compared when ready_o rises.
module tb_ex_div;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  vec_t        vecs[$];

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    sb_q.push_back(exp);
  endtask

  // Edge N is the first posedge counted (n=1); ready must first appear after edge N+exp_edges-1.
  task automatic wait_result(input string name, input int exp_edges, output logic [63:0] got_exp);
    int   n = 0;
    logic busy_nz = 1'b0;
    got_exp = 64'd0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_o) break;
      if (result_o !== 64'd0) busy_nz = 1'b1;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
    chk({name, " latency"}, 64'(n), 64'(exp_edges));
    chk({name, " busy_result"}, 64'(busy_nz), 64'd0);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=%h required=none", name, result_o);
    end else begin
      got_exp = sb_q.pop_front();
      chk({name, " result"}, result_o, got_exp);
    end
  endtask

  // Result must hold through an annul while start stays high, then clear once start drops.
  task automatic finish_div(input string name, input logic [63:0] exp);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " hold_ready"}, 64'(ready_o), 64'd1);
    chk({name, " hold_result"}, result_o, exp);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " drop_ready"}, 64'(ready_o), 64'd0);
    chk({name, " drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [63:0]        e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        ua;
    logic [31:0]        ub;
    logic               sg;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 "u100_7"});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          {32'hFFFF_FFFE, 32'hFFFF_FFF2},  "sm100_7"});
    vecs.push_back('{1'b1, 32'd100,        32'hFFFF_FFF9,  {32'h0000_0002, 32'hFFFF_FFF2},  "s100_m7"});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          "umax_1"});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          "smin_m1"});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0},          "umin_max"});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3},          "sm7_m2"});
    vecs.push_back('{1'b0, 32'd5,          32'd10,         {32'd5, 32'd0},                  "u5_10"});

    #2;
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      start_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_result(vecs[i].name, 34, e);
      finish_div(vecs[i].name, e);
    end

    start_div(1'b1, 32'd1234, 32'd0, 64'd0);
    wait_result("divzero_s", 2, e);
    finish_div("divzero_s", e);
    start_div(1'b0, 32'hFFFF_FFFF, 32'd0, 64'd0);
    wait_result("divzero_u", 2, e);
    finish_div("divzero_u", e);

    for (int k = 0; k < 4; k++) begin
      sg = 1'($urandom_range(0, 1));
      ua = $urandom;
      ub = 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) ub = -ub;
      if (sg) begin
        sa = $signed(ua);
        sb = $signed(ub);
        sq = sa / sb;
        sr = sa % sb;
        e  = {sr, sq};
      end else begin
        e = {ua % ub, ua / ub};
      end
      start_div(sg, ua, ub, e);
      wait_result("random", 34, e);
      finish_div("random", e);
    end

    // start with annul in DIV_FREE is ignored; dropping annul makes the next edge N
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd20;
    opdata2_i    = 32'd4;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("free_annul ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    sb_q.push_back({32'd0, 32'd5});
    wait_result("free_annul", 34, e);
    finish_div("free_annul", e);

    // annul on edge N+10, restart on N+11
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul ready", 64'(ready_o), 64'd0);
    chk("annul result", result_o, 64'd0);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    sb_q.push_back({32'd0, 32'd3});
    wait_result("after_annul", 34, e);
    finish_div("after_annul", e);

    // reset in DIV_ON, then a new start on the first edge after release
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd77;
    opdata2_i    = 32'd8;
    start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_on ready", 64'(ready_o), 64'd0);
    chk("rst_on result", result_o, 64'd0);
    @(negedge clk);
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    sb_q.push_back({32'd2, 32'd14});
    wait_result("rst_restart", 34, e);

    // reset while a result is held clears outputs without a clock edge
    #2;
    rst = 1'b0;
    #1;
    chk("rst_end ready", 64'(ready_o), 64'd0);
    chk("rst_end result", result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst ready", 64'(ready_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
